delay_sample_mc: RTL

DELAY_SAMPLE_MC -- requirements
Module: delay_sample_mc

---
 rtl/dly_sample_pkg.sv | 20 ++
 rtl/dly_sample_ch.sv | 96 +++++++++
 rtl/delay_sample_mc.sv | 40 ++++
 3 files changed

// File: rtl/dly_sample_pkg.sv
// Shared definitions for the delayed multi-channel sampler: FSM encoding,
// mode constants and the enable edge-detect rule.
package dly_sample_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_e;

  localparam int unsigned MODE_LEVEL  = 0;
  localparam int unsigned MODE_TOGGLE = 1;
  localparam int unsigned CNT_W       = 4;

  function automatic logic edge_event(input int unsigned mode, input logic en_s,
                                      input logic en_d);
    return (mode == MODE_TOGGLE) ? (en_s ^ en_d) : (en_s & ~en_d);
  endfunction

endpackage

// File: rtl/dly_sample_ch.sv
// One channel: enable synchroniser, edge detect, delay counter FSM,
// data capture register and sticky overrun flag.
module dly_sample_ch
  import dly_sample_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DLY         = 1,
  parameter int unsigned MODE        = MODE_LEVEL
) (
  input  logic          clkb,
  input  logic          rstn,
  input  logic [DW-1:0] din,
  input  logic          din_en,
  input  logic          ovf_clr,
  output logic [DW-1:0] dout,
  output logic          dout_en,
  output logic          ovf
);

  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(DLY);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   en_d_q;
  logic                   ev_d, ev_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]          dout_q, dout_d;
  logic                   dout_en_q;
  logic                   ovf_q, ovf_d;

  assign ev_d = edge_event(MODE, sync_q[SYNC_STAGES-1], en_d_q);

  // Event and strobe are both registered; together with the sync chain and
  // en_d this yields SYNC_STAGES + DLY + 3 edges from sampling to dout_en.
  always_ff @(posedge clkb or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '0;
      en_d_q    <= 1'b0;
      ev_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], din_en};
      en_d_q    <= sync_q[SYNC_STAGES-1];
      ev_q      <= ev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      dout_en_q <= (state_q == CAPT);
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q & ~ovf_clr;
    unique case (state_q)
      IDLE: begin
        if (ev_q) begin
          cnt_d   = DLY_C;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A second event while waiting is dropped; set overrides clear.
        if (ev_q) ovf_d = 1'b1;
        if (cnt_q == '0) begin
          dout_d  = din;
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPT: begin
        if (ev_q) begin
          cnt_d   = DLY_C;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout    = dout_q;
  assign dout_en = dout_en_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/delay_sample_mc.sv
// Multi-channel delayed sampler: CH independent channels capturing
// asynchronous data a fixed number of clkb cycles after an enable event.
module delay_sample_mc
  import dly_sample_pkg::*;
#(
  parameter int unsigned CH          = 2,
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DLY         = 1,
  parameter int unsigned MODE        = MODE_LEVEL
) (
  input  logic             clkb,
  input  logic             rstn,
  input  logic [CH*DW-1:0] din,
  input  logic [CH-1:0]    din_en,
  input  logic [CH-1:0]    ovf_clr,
  output logic [CH*DW-1:0] dout,
  output logic [CH-1:0]    dout_en,
  output logic [CH-1:0]    ovf
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    dly_sample_ch #(
      .DW         (DW),
      .SYNC_STAGES(SYNC_STAGES),
      .DLY        (DLY),
      .MODE       (MODE)
    ) u_ch (
      .clkb   (clkb),
      .rstn   (rstn),
      .din    (din[i*DW +: DW]),
      .din_en (din_en[i]),
      .ovf_clr(ovf_clr[i]),
      .dout   (dout[i*DW +: DW]),
      .dout_en(dout_en[i]),
      .ovf    (ovf[i])
    );
  end

endmodule
